// File: rtl/time_entry_ctrl.sv
`timescale 1ns/1ps
// time_entry_ctrl: turns four keypad digits into a validated HH:MM and loads clock or alarm time
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   keypad_values      four BCD digits from the keypad, [15:12] oldest, 4'ha = blank
//   shift_pulse        keypad shift strobe (asynchronous to clk)
//   set_time/set_alarm level requests to start a clock/alarm entry
//   cancel             level abort request
//   hours_bcd/minutes_bcd  last validated value, held between loads
//   load_time/load_alarm   one-cycle load strobes
//   entry_active       high while collecting or validating
//   entry_error        high for ERR_CYCLES after a rejected entry
//   timeout            one-cycle strobe on inactivity abort
//   digit_count        digits accepted in the current entry
module time_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int ERR_CYCLES = 25000000,
  parameter int TIMER_W = 29
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keypad_values,
  input  logic        shift_pulse,
  input  logic        set_time,
  input  logic        set_alarm,
  input  logic        cancel,
  output logic [7:0]  hours_bcd,
  output logic [7:0]  minutes_bcd,
  output logic        load_time,
  output logic        load_alarm,
  output logic        entry_active,
  output logic        entry_error,
  output logic        timeout,
  output logic [2:0]  digit_count
);
  typedef enum logic [2:0] {IDLE, COLLECT, VALIDATE, LOAD, ERROR} state_t;
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ERR_LAST = TIMER_W'(ERR_CYCLES - 1);
  state_t state;
  logic [2:0] sync_shift, sync_time, sync_alarm, sync_cancel;
  logic [TIMER_W-1:0] timer;
  logic [15:0] capture;
  logic target_alarm;
  logic shift_rise, time_rise, alarm_rise, cancel_rise, digit_ok, valid;
  // two flops of synchronization, the third holds the previous level for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_shift <= '0;
      sync_time <= '0;
      sync_alarm <= '0;
      sync_cancel <= '0;
    end else begin
      sync_shift <= {sync_shift[1:0], shift_pulse};
      sync_time <= {sync_time[1:0], set_time};
      sync_alarm <= {sync_alarm[1:0], set_alarm};
      sync_cancel <= {sync_cancel[1:0], cancel};
    end
  end
  always_comb begin
    shift_rise = sync_shift[1] & ~sync_shift[2];
    time_rise = sync_time[1] & ~sync_time[2];
    alarm_rise = sync_alarm[1] & ~sync_alarm[2];
    cancel_rise = sync_cancel[1] & ~sync_cancel[2];
    digit_ok = keypad_values[3:0] <= 4'd9;
    valid = capture[15:12] <= 4'd2 && capture[11:8] <= 4'd9 &&
            !(capture[15:12] == 4'd2 && capture[11:8] > 4'd3) &&
            capture[7:4] <= 4'd5 && capture[3:0] <= 4'd9;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      capture <= '0;
      target_alarm <= 1'b0;
      hours_bcd <= '0;
      minutes_bcd <= '0;
      load_time <= 1'b0;
      load_alarm <= 1'b0;
      entry_active <= 1'b0;
      entry_error <= 1'b0;
      timeout <= 1'b0;
      digit_count <= '0;
    end else begin
      load_time <= 1'b0;
      load_alarm <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (time_rise || alarm_rise) begin
          state <= COLLECT;
          target_alarm <= !time_rise;
          digit_count <= '0;
          timer <= '0;
          entry_active <= 1'b1;
        end
        COLLECT: if (digit_count == 3'd4) begin
          state <= VALIDATE;
        end else if (cancel_rise) begin
          state <= IDLE;
          digit_count <= '0;
          entry_active <= 1'b0;
        end else if (shift_rise) begin
          // any keypad activity, even a blank, restarts the inactivity window
          timer <= '0;
          if (digit_ok) begin
            digit_count <= digit_count + 3'd1;
            capture <= keypad_values;
          end
        end else if (timer == TO_LAST) begin
          state <= IDLE;
          timeout <= 1'b1;
          digit_count <= '0;
          entry_active <= 1'b0;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
        VALIDATE: begin
          entry_active <= 1'b0;
          if (valid) begin
            state <= LOAD;
            hours_bcd <= capture[15:8];
            minutes_bcd <= capture[7:0];
            load_time <= !target_alarm;
            load_alarm <= target_alarm;
          end else begin
            state <= ERROR;
            entry_error <= 1'b1;
            timer <= '0;
          end
        end
        LOAD: begin
          state <= IDLE;
          digit_count <= '0;
        end
        ERROR: if (timer == ERR_LAST) begin
          state <= IDLE;
          entry_error <= 1'b0;
          digit_count <= '0;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
